// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared encodings for the fighting-game referee: action codes,
//                winner codes, referee FSM states, player position constants
//                and the end-of-turn judging function.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Action codes understood by the player modules
    typedef logic [2:0] action_t;
    localparam action_t ACT_KICK   = 3'b000;
    localparam action_t ACT_PUNCH  = 3'b001;
    localparam action_t ACT_AWAIT  = 3'b010;
    localparam action_t ACT_JUMP   = 3'b011;
    localparam action_t ACT_LEFT1  = 3'b100;
    localparam action_t ACT_LEFT2  = 3'b101;
    localparam action_t ACT_RIGHT1 = 3'b110;
    localparam action_t ACT_RIGHT2 = 3'b111;

    // Winner codes
    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;

    // Referee turn sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CHECK   = 3'd4,
        ST_OVER    = 3'd5
    } state_e;

    // Player position one-hot constants (arena squares, left to right)
    typedef logic [3:0] position_t;
    localparam position_t POS_0 = 4'b0001;
    localparam position_t POS_1 = 4'b0010;
    localparam position_t POS_2 = 4'b0100;
    localparam position_t POS_3 = 4'b1000;

    // Knockouts take priority; the health comparison only applies at the turn limit
    function automatic winner_t judge(input logic [1:0] h1,
                                      input logic [1:0] h2,
                                      input logic       at_limit);
        winner_t w;
        w = WIN_NONE;
        if (h1 == 2'd0 && h2 == 2'd0) begin
            w = WIN_DRAW;
        end else if (h1 == 2'd0) begin
            w = WIN_P2;
        end else if (h2 == 2'd0) begin
            w = WIN_P1;
        end else if (at_limit) begin
            if (h1 > h2) begin
                w = WIN_P1;
            end else if (h2 > h1) begin
                w = WIN_P2;
            end else begin
                w = WIN_DRAW;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_referee_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_referee_if
//  Description : Bundle of the referee's input-unit handshake, player-module
//                drive and game status signals. The master modport is the
//                referee side; the slave modport is the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_referee_if;
    import game_pkg::*;

    logic          start;
    logic          ready1;
    logic          ready2;
    action_t       actIn1;
    action_t       actIn2;
    logic          ack1;
    logic          ack2;
    action_t       action1;
    action_t       action2;
    logic          actionEnable;
    logic [1:0]    health1;
    logic [1:0]    health2;
    logic          isGameOver;
    winner_t       winner;
    logic [7:0]    turnCount;

    modport master (
        input  start, ready1, ready2, actIn1, actIn2, health1, health2,
        output ack1, ack2, action1, action2, actionEnable,
               isGameOver, winner, turnCount
    );

    modport slave (
        output start, ready1, ready2, actIn1, actIn2, health1, health2,
        input  ack1, ack2, action1, action2, actionEnable,
               isGameOver, winner, turnCount
    );

endinterface
`default_nettype wire

// File: rtl/player_action_latch.sv
`default_nettype none
// ============================================================================
//  Module      : player_action_latch
//  Description : Per-player capture flag, action register and one-cycle ack
//                pulse. Captures at most one action per turn while collecting;
//                an uncaptured player can be forced to await.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_action_latch
    import game_pkg::*;
(
    input  logic    clk,
    input  logic    reset,        // asynchronous, active-low
    input  logic    clear,        // start of a new collection window
    input  logic    collect_en,   // referee is in COLLECT
    input  logic    ready,
    input  action_t act_in,
    input  logic    force_await,  // collection window expired
    output logic    captured,
    output action_t action,
    output logic    ack
);

    logic    captured_q, captured_d;
    action_t action_q,   action_d;
    logic    ack_q,      ack_d;
    logic    w_capture;

    assign w_capture = collect_en & ready & ~captured_q;

    // Next-state for flag, action and ack; a real capture beats a forced await
    always_comb begin
        captured_d = captured_q;
        action_d   = action_q;
        ack_d      = w_capture;
        if (clear) begin
            captured_d = 1'b0;
        end else if (w_capture) begin
            captured_d = 1'b1;
        end
        if (w_capture) begin
            action_d = act_in;
        end else if (force_await && !captured_q) begin
            action_d = ACT_AWAIT;
        end
    end

    // Registers, reset to "await" with no pending capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captured_q <= 1'b0;
            action_q   <= ACT_AWAIT;
            ack_q      <= 1'b0;
        end else begin
            captured_q <= captured_d;
            action_q   <= action_d;
            ack_q      <= ack_d;
        end
    end

    assign captured = captured_q;
    assign action   = action_q;
    assign ack      = ack_q;

endmodule
`default_nettype wire

// File: rtl/game_referee.sv
`default_nettype none
// ============================================================================
//  Module      : game_referee
//  Description : Turn sequencer and referee for the two-player fighting game.
//                Collects one action per player, strobes the player modules,
//                waits for health to settle, then judges knockout / turn limit.
//                Optional build macro REFEREE_TIMEOUT_EN forces missing actions
//                to await after TURN_TIMEOUT cycles in COLLECT.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_referee
    import game_pkg::*;
#(
    parameter int unsigned MAX_TURNS     = 15,   // 1..255
    parameter int unsigned ENABLE_CYCLES = 2,    // >= 1
    parameter int unsigned SETTLE_CYCLES = 2,    // >= 1
    parameter int unsigned TURN_TIMEOUT  = 255   // >= 1
) (
    input  logic           clk,
    input  logic           reset,   // asynchronous, active-low
    game_referee_if.master bus
);

    localparam int unsigned     PH_W        = 16;
    localparam logic [PH_W-1:0] ENABLE_LAST = PH_W'(ENABLE_CYCLES - 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]      TURN_LIMIT  = 8'(MAX_TURNS);

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [7:0]      turn_count_q, turn_count_d;
    winner_t         winner_q, winner_d;
    logic            game_over_q, game_over_d;
    logic            action_enable_q, action_enable_d;

    logic            w_cap1, w_cap2;
    logic            w_collect;
    logic            w_enter_collect;
    logic            w_expire;
    logic [7:0]      w_turn_next;
    winner_t         w_verdict;

    assign w_collect       = (state_q == ST_COLLECT);
    assign w_enter_collect = (state_q != ST_COLLECT) && (state_d == ST_COLLECT);
    assign w_turn_next     = (turn_count_q == 8'hFF) ? 8'hFF : turn_count_q + 8'd1;
    assign w_verdict       = (state_q == ST_CHECK)
                           ? judge(bus.health1, bus.health2, w_turn_next == TURN_LIMIT)
                           : WIN_NONE;

`ifdef REFEREE_TIMEOUT_EN
    localparam int unsigned TO_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Collection-window counter, restarted on every entry into COLLECT
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (w_enter_collect) begin
            to_cnt_d = '0;
        end else if (w_collect) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Collection-window counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign w_expire = w_collect && (to_cnt_q == TO_LAST);
`else
    assign w_expire = 1'b0;
`endif

    player_action_latch u_latch1 (
        .clk         (clk),
        .reset       (reset),
        .clear       (w_enter_collect),
        .collect_en  (w_collect),
        .ready       (bus.ready1),
        .act_in      (bus.actIn1),
        .force_await (w_expire),
        .captured    (w_cap1),
        .action      (bus.action1),
        .ack         (bus.ack1)
    );

    player_action_latch u_latch2 (
        .clk         (clk),
        .reset       (reset),
        .clear       (w_enter_collect),
        .collect_en  (w_collect),
        .ready       (bus.ready2),
        .act_in      (bus.actIn2),
        .force_await (w_expire),
        .captured    (w_cap2),
        .action      (bus.action2),
        .ack         (bus.ack2)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; OVER is left only through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_COLLECT;
            ST_COLLECT: if ((w_cap1 && w_cap2) || w_expire) state_d = ST_STROBE;
            ST_STROBE:  if (phase_q == ENABLE_LAST) state_d = ST_RELEASE;
            ST_RELEASE: if (phase_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK:   state_d = (w_verdict != WIN_NONE) ? ST_OVER : ST_COLLECT;
            ST_OVER:    state_d = ST_OVER;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic: registered outputs are computed from the upcoming state
    always_comb begin
        phase_d = '0;
        if ((state_d == state_q) && (state_q == ST_STROBE || state_q == ST_RELEASE)) begin
            phase_d = phase_q + 1'b1;
        end
        action_enable_d = (state_d == ST_STROBE);
        game_over_d     = (state_d == ST_OVER);
        turn_count_d    = turn_count_q;
        winner_d        = winner_q;
        if (state_q == ST_CHECK) begin
            turn_count_d = w_turn_next;
            winner_d     = w_verdict;
        end
    end

    // Output and phase registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q         <= '0;
            action_enable_q <= 1'b0;
            game_over_q     <= 1'b0;
            turn_count_q    <= 8'd0;
            winner_q        <= WIN_NONE;
        end else begin
            phase_q         <= phase_d;
            action_enable_q <= action_enable_d;
            game_over_q     <= game_over_d;
            turn_count_q    <= turn_count_d;
            winner_q        <= winner_d;
        end
    end

    assign bus.actionEnable = action_enable_q;
    assign bus.isGameOver   = game_over_q;
    assign bus.winner       = winner_q;
    assign bus.turnCount    = turn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_game_referee.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_referee
//  Description : Directed self-checking bench for game_referee
//                (MAX_TURNS=3, ENABLE_CYCLES=2, SETTLE_CYCLES=2, TURN_TIMEOUT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_referee;
    import game_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    game_referee_if bus();

    game_referee #(
        .MAX_TURNS     (3),
        .ENABLE_CYCLES (2),
        .SETTLE_CYCLES (2),
        .TURN_TIMEOUT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Both players offer an action; returns one cycle into the state after CHECK
    task automatic play_turn(input logic [2:0] a1, input logic [2:0] a2);
        bit got_ack;
        got_ack    = 1'b0;
        bus.ready1 = 1'b1;
        bus.actIn1 = a1;
        bus.ready2 = 1'b1;
        bus.actIn2 = a2;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            tick();
            if (bus.ack1 && bus.ack2) got_ack = 1'b1;
        end
        bus.ready1 = 1'b0;
        bus.ready2 = 1'b0;
        check("turn_ack", 32'(got_ack), 32'd1);
        repeat (6) tick();
    endtask

    initial begin
        int en_cnt;
        bit ack_seen;
        bit en_seen;
        bit ack2_seen;

        n_total    = 0;
        n_pass     = 0;
        bus.start  = 1'b0;
        bus.ready1 = 1'b0;
        bus.ready2 = 1'b0;
        bus.actIn1 = ACT_AWAIT;
        bus.actIn2 = ACT_AWAIT;
        bus.health1 = 2'd3;
        bus.health2 = 2'd3;
        reset      = 1'b0;

        // ---------------- reset values
        repeat (2) tick();
        check("rst_action1",  32'(bus.action1),      32'h2);
        check("rst_action2",  32'(bus.action2),      32'h2);
        check("rst_enable",   32'(bus.actionEnable), 32'h0);
        check("rst_ack",      32'({bus.ack1, bus.ack2}), 32'h0);
        check("rst_over",     32'(bus.isGameOver),   32'h0);
        check("rst_winner",   32'(bus.winner),       32'h0);
        check("rst_turns",    32'(bus.turnCount),    32'h0);
        reset = 1'b1;
        tick();

        // ---------------- game 1: normal turn, then knockout
        start_game();
        bus.ready1 = 1'b1; bus.actIn1 = ACT_KICK;
        bus.ready2 = 1'b1; bus.actIn2 = ACT_PUNCH;
        tick();
        check("t1_ack1",    32'(bus.ack1),         32'h1);
        check("t1_ack2",    32'(bus.ack2),         32'h1);
        check("t1_action1", 32'(bus.action1),      32'h0);
        check("t1_action2", 32'(bus.action2),      32'h1);
        check("t1_en_early", 32'(bus.actionEnable), 32'h0);
        bus.ready1 = 1'b0;
        bus.ready2 = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) check("t1_ack_pulse", 32'(bus.ack1 | bus.ack2), 32'h0);
            if (bus.actionEnable) en_cnt++;
        end
        check("t1_en_cycles", 32'(en_cnt),         32'd2);
        check("t1_turns",     32'(bus.turnCount),  32'd1);
        check("t1_winner",    32'(bus.winner),     32'h0);
        check("t1_over",      32'(bus.isGameOver), 32'h0);

        bus.health2 = 2'd0;
        play_turn(ACT_JUMP, ACT_LEFT1);
        check("ko_winner", 32'(bus.winner),       32'h1);
        check("ko_over",   32'(bus.isGameOver),   32'h1);
        check("ko_turns",  32'(bus.turnCount),    32'd2);
        check("ko_enable", 32'(bus.actionEnable), 32'h0);

        // OVER ignores start, ready and health
        bus.start = 1'b1; bus.ready1 = 1'b1; bus.ready2 = 1'b1;
        bus.health1 = 2'd0; bus.health2 = 2'd3;
        ack_seen = 1'b0; en_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.ack1 || bus.ack2) ack_seen = 1'b1;
            if (bus.actionEnable) en_seen = 1'b1;
        end
        bus.start = 1'b0; bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        check("over_no_ack",    32'(ack_seen),       32'h0);
        check("over_no_enable", 32'(en_seen),        32'h0);
        check("over_winner",    32'(bus.winner),     32'h1);
        check("over_turns",     32'(bus.turnCount),  32'd2);
        check("over_held",      32'(bus.isGameOver), 32'h1);

        // ---------------- game 2: late ready, then turn limit with 11 vs 10
        bus.health1 = 2'd3; bus.health2 = 2'd3;
        do_reset();
        start_game();
        bus.ready1 = 1'b1; bus.actIn1 = ACT_PUNCH;
        bus.ready2 = 1'b1; bus.actIn2 = ACT_KICK;
        tick();
        check("g2_ack1", 32'(bus.ack1), 32'h1);
        bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        repeat (3) tick();                    // STROBE, STROBE, RELEASE
        check("g2_release_en", 32'(bus.actionEnable), 32'h0);
        bus.ready1 = 1'b1; bus.actIn1 = ACT_LEFT2;
        tick();                               // RELEASE
        check("late_ack_release", 32'(bus.ack1), 32'h0);
        tick();                               // CHECK
        check("late_ack_check",   32'(bus.ack1),    32'h0);
        check("late_action_held", 32'(bus.action1), 32'(ACT_PUNCH));
        tick();                               // first COLLECT cycle
        check("late_ack_c1",  32'(bus.ack1),      32'h0);
        check("late_turns",   32'(bus.turnCount), 32'd1);
        tick();
        check("late_ack_c2",    32'(bus.ack1),    32'h1);
        check("late_action1",   32'(bus.action1), 32'(ACT_LEFT2));
        bus.ready1 = 1'b0;
        bus.ready2 = 1'b1; bus.actIn2 = ACT_PUNCH;
        tick();
        check("late_ack2",      32'(bus.ack2), 32'h1);
        check("late_ack1_once", 32'(bus.ack1), 32'h0);
        bus.ready2 = 1'b0;
        repeat (6) tick();
        check("g2_turns2", 32'(bus.turnCount), 32'd2);
        bus.health1 = 2'd3; bus.health2 = 2'd2;
        play_turn(ACT_KICK, ACT_KICK);
        check("limit_winner", 32'(bus.winner),     32'h1);
        check("limit_turns",  32'(bus.turnCount),  32'd3);
        check("limit_over",   32'(bus.isGameOver), 32'h1);

        // ---------------- game 3: turn limit with equal health -> draw
        bus.health1 = 2'd2; bus.health2 = 2'd2;
        do_reset();
        start_game();
        play_turn(ACT_JUMP, ACT_JUMP);
        play_turn(ACT_RIGHT1, ACT_LEFT1);
        check("eq_pre_winner", 32'(bus.winner),     32'h0);
        check("eq_pre_over",   32'(bus.isGameOver), 32'h0);
        play_turn(ACT_PUNCH, ACT_PUNCH);
        check("eq_winner", 32'(bus.winner),     32'h3);
        check("eq_turns",  32'(bus.turnCount),  32'd3);
        check("eq_over",   32'(bus.isGameOver), 32'h1);

        // ---------------- game 4: player 1 knocked out on first turn
        bus.health1 = 2'd0; bus.health2 = 2'd1;
        do_reset();
        start_game();
        play_turn(ACT_KICK, ACT_KICK);
        check("ko1_winner", 32'(bus.winner),    32'h2);
        check("ko1_turns",  32'(bus.turnCount), 32'd1);

        // ---------------- game 5: asynchronous reset during STROBE
        bus.health1 = 2'd3; bus.health2 = 2'd3;
        do_reset();
        start_game();
        play_turn(ACT_KICK, ACT_PUNCH);
        bus.ready1 = 1'b1; bus.actIn1 = ACT_JUMP;
        bus.ready2 = 1'b1; bus.actIn2 = ACT_RIGHT2;
        tick();
        bus.ready1 = 1'b0; bus.ready2 = 1'b0;
        tick();
        check("strobe_en",    32'(bus.actionEnable), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_enable",  32'(bus.actionEnable), 32'h0);
        check("arst_action1", 32'(bus.action1),      32'h2);
        check("arst_action2", 32'(bus.action2),      32'h2);
        check("arst_turns",   32'(bus.turnCount),    32'h0);
        check("arst_winner",  32'(bus.winner),       32'h0);
        check("arst_over",    32'(bus.isGameOver),   32'h0);
        tick();
        reset = 1'b1;
        bus.ready1 = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ack1) ack_seen = 1'b1;
        end
        bus.ready1 = 1'b0;
        check("arst_idle_no_ack", 32'(ack_seen), 32'h0);

`ifdef REFEREE_TIMEOUT_EN
        // ---------------- game 6: only player 1 answers, window expires
        start_game();
        play_turn(ACT_KICK, ACT_JUMP);
        bus.ready1 = 1'b1; bus.actIn1 = ACT_PUNCH;
        ack_seen = 1'b0; ack2_seen = 1'b0; en_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.ack1) begin
                ack_seen   = 1'b1;
                bus.ready1 = 1'b0;
            end
            if (bus.ack2) ack2_seen = 1'b1;
            if (bus.actionEnable) en_seen = 1'b1;
        end
        check("to_wait_enable",  32'(en_seen),     32'h0);
        check("to_wait_action2", 32'(bus.action2), 32'(ACT_JUMP));
        tick();
        if (bus.ack2) ack2_seen = 1'b1;
        check("to_strobe",  32'(bus.actionEnable), 32'h1);
        check("to_action2", 32'(bus.action2),      32'(ACT_AWAIT));
        check("to_action1", 32'(bus.action1),      32'(ACT_PUNCH));
        check("to_ack1",    32'(ack_seen),         32'h1);
        check("to_no_ack2", 32'(ack2_seen),        32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
